mem_port_arbiter: RTL and testbench

Arbitrates a single unified memory port between the pipeline's instruction-fetch stage (IF) and memory stage (MEM). It serialises requests, generates byte enables from the store-width encoding produced by the control unit, and returns read data with a one-cycle acknowledge pulse. It drives per-stage stall outputs that the pipeline hazard logic uses to freeze IF and MEM. It sits between the pipeline stages and the memory/bus model.

---
 rtl/mem_arb_pkg.sv | 38 +++
 rtl/mem_arb_lane_align.sv | 26 ++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, MemWe store-width
// encodings, grant encoding and the registered bus request bundle.
package mem_arb_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Matches the control unit's MemWrite field
    typedef enum logic [1:0] {
        MEM_WE_NONE = 2'b00,
        MEM_WE_BYTE = 2'b01,
        MEM_WE_HALF = 2'b10,
        MEM_WE_WORD = 2'b11
    } mem_we_e;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } gnt_e;

    typedef struct packed {
        logic                 we;
        logic [NUM_LANES-1:0] be;
        logic [31:0]          addr;
        logic [31:0]          wdata;
    } bus_req_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_arb_lane_align.sv
// Combinational byte-lane steering: store width and low address bits to byte
// enables and lane-replicated write data.
module mem_arb_lane_align
    import mem_arb_pkg::*;
(
    input  mem_we_e              we,
    input  logic [1:0]           addr_lo,
    input  logic [31:0]          wdata,
    output logic [NUM_LANES-1:0] be,
    output logic [31:0]          wdata_rep
);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        // Loads and word stores enable every lane
        assign be[l] = (we == MEM_WE_BYTE) ? (int'(addr_lo) == l) :
                       (we == MEM_WE_HALF) ? (addr_lo[1] == (l >= 2)) :
                                             1'b1;

        assign wdata_rep[l*LANE_W +: LANE_W] =
            (we == MEM_WE_BYTE) ? wdata[LANE_W-1:0] :
            (we == MEM_WE_HALF) ? wdata[(l % 2)*LANE_W +: LANE_W] :
            (we == MEM_WE_WORD) ? wdata[l*LANE_W +: LANE_W] :
                                  '0;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by IF and MEM; MEM has priority. Define
// ARB_STARVE_GUARD_EN to force IF through after STARVE_MAX consecutive MEM wins.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        IfReq,
    input  logic [31:0] IfAddr,
    output logic [31:0] IfRdata,
    output logic        IfAck,
    input  logic        MemReq,
    input  logic [1:0]  MemWe,
    input  logic [31:0] MemAddr,
    input  logic [31:0] MemWdata,
    output logic [31:0] MemRdata,
    output logic        MemAck,
    output logic        IfStall,
    output logic        MemStall,
    output logic        BusReq,
    output logic        BusWe,
    output logic [3:0]  BusBe,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWdata,
    input  logic        BusReady,
    input  logic [31:0] BusRdata
);

    arb_state_e           state;
    gnt_e                 gnt;
    gnt_e                 win;
    logic                 if_forced;
    logic [NUM_LANES-1:0] mem_be;
    logic [31:0]          mem_wdata_rep;
    bus_req_t             nxt;

    mem_arb_lane_align u_align (
        .we        (mem_we_e'(MemWe)),
        .addr_lo   (MemAddr[1:0]),
        .wdata     (MemWdata),
        .be        (mem_be),
        .wdata_rep (mem_wdata_rep)
    );

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    assign if_forced = IfReq & MemReq & (starve_cnt == 4'(STARVE_MAX));

    // Counts MEM wins that left a waiting IF request behind
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            starve_cnt <= '0;
        end else if (state == IDLE && (IfReq || MemReq)) begin
            if (win == GNT_IF)
                starve_cnt <= '0;
            else if (IfReq)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign if_forced = 1'b0;
`endif

    assign win = (MemReq && !if_forced) ? GNT_MEM : GNT_IF;

    always_comb begin
        nxt = '0;
        if (win == GNT_MEM) begin
            nxt.we    = (MemWe != MEM_WE_NONE);
            nxt.be    = mem_be;
            nxt.addr  = word_align(MemAddr);
            nxt.wdata = mem_wdata_rep;
        end else begin
            nxt.be    = '1;
            nxt.addr  = word_align(IfAddr);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            gnt      <= GNT_IF;
            BusReq   <= 1'b0;
            BusWe    <= 1'b0;
            BusBe    <= '0;
            BusAddr  <= '0;
            BusWdata <= '0;
            IfRdata  <= '0;
            MemRdata <= '0;
            IfAck    <= 1'b0;
            MemAck   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (IfReq || MemReq) begin
                        gnt      <= win;
                        BusReq   <= 1'b1;
                        BusWe    <= nxt.we;
                        BusBe    <= nxt.be;
                        BusAddr  <= nxt.addr;
                        BusWdata <= nxt.wdata;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (BusReady) begin
                        BusReq <= 1'b0;
                        if (gnt == GNT_MEM) begin
                            MemRdata <= BusRdata;
                            MemAck   <= 1'b1;
                        end else begin
                            IfRdata  <= BusRdata;
                            IfAck    <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    IfAck  <= 1'b0;
                    MemAck <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign IfStall  = IfReq & ~IfAck;
    assign MemStall = MemReq & ~MemAck;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of the
// arbitration, lane-steering and latency rules.
module tb_mem_port_arbiter;

    localparam int SMAX = 2;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        Clk = 1'b0, Reset_n = 1'b0;
    logic        IfReq = 1'b0, MemReq = 1'b0, BusReady = 1'b0;
    logic [31:0] IfAddr = '0, MemAddr = '0, MemWdata = '0, BusRdata = '0;
    logic [1:0]  MemWe = '0;
    logic [31:0] IfRdata, MemRdata, BusAddr, BusWdata;
    logic        IfAck, MemAck, IfStall, MemStall, BusReq, BusWe;
    logic [3:0]  BusBe;

    always #5 Clk = ~Clk;

    mem_port_arbiter #(.STARVE_MAX(SMAX)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .IfReq(IfReq), .IfAddr(IfAddr), .IfRdata(IfRdata), .IfAck(IfAck),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
        .MemRdata(MemRdata), .MemAck(MemAck),
        .IfStall(IfStall), .MemStall(MemStall),
        .BusReq(BusReq), .BusWe(BusWe), .BusBe(BusBe), .BusAddr(BusAddr),
        .BusWdata(BusWdata), .BusReady(BusReady), .BusRdata(BusRdata)
    );

    int          n_chk = 0, n_fail = 0;
    int          starve = 0;
    logic [31:0] exp_if_rd = '0, exp_mem_rd = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_be(input logic [1:0] we, input logic [31:0] a);
        case (we)
            2'd1:    return 4'b0001 << a[1:0];
            2'd2:    return 4'b0011 << (2 * a[1]);
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] exp_wd(input logic [1:0] we, input logic [31:0] w);
        case (we)
            2'd1:    return {4{w[7:0]}};
            2'd2:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    // Entered just after a negedge of an IDLE cycle with requests already driven;
    // returns at posedge+1 of the next IDLE cycle.
    task automatic serve(input int k, input bit drop_mid, input logic [31:0] rd);
        bit          mem_win, we;
        logic [3:0]  be;
        logic [31:0] addr, wd;
        mem_win = MemReq && !(IfReq && GUARD && starve == SMAX);
        if (!mem_win) starve = 0;
        else if (IfReq) starve++;
        if (mem_win) begin
            we = (MemWe != 2'd0); be = exp_be(MemWe, MemAddr);
            addr = MemAddr & ~32'h3; wd = exp_wd(MemWe, MemWdata);
        end else begin
            we = 1'b0; be = 4'hf; addr = IfAddr & ~32'h3; wd = '0;
        end
        @(posedge Clk); #1;
        chk("bus_req", BusReq, 1);
        chk("bus_we", BusWe, we);
        chk("bus_be", BusBe, be);
        chk("bus_addr", BusAddr, addr);
        if (we) chk("bus_wdata", BusWdata, wd);
        for (int i = 0; i < k; i++) begin
            @(negedge Clk);
            if (drop_mid && i == 0) begin
                if (mem_win) MemReq = 1'b0; else IfReq = 1'b0;
            end
            @(posedge Clk); #1;
            chk("hold_req", BusReq, 1);
            chk("hold_addr", BusAddr, addr);
            chk("wait_ack", {IfAck, MemAck}, 0);
            chk("wait_if_stall", IfStall, IfReq);
            chk("wait_mem_stall", MemStall, MemReq);
        end
        @(negedge Clk); BusReady = 1'b1; BusRdata = rd;
        @(posedge Clk); #1; BusReady = 1'b0; BusRdata = $urandom;
        if (mem_win) exp_mem_rd = rd; else exp_if_rd = rd;
        chk("if_ack", IfAck, !mem_win);
        chk("mem_ack", MemAck, mem_win);
        chk("if_rdata", IfRdata, exp_if_rd);
        chk("mem_rdata", MemRdata, exp_mem_rd);
        chk("bus_req_done", BusReq, 0);
        chk("if_stall_ack", IfStall, IfReq && mem_win);
        chk("mem_stall_ack", MemStall, MemReq && !mem_win);
        @(negedge Clk);
        if (mem_win) MemReq = 1'b0; else IfReq = 1'b0;
        @(posedge Clk); #1;
        chk("idle_ack", {IfAck, MemAck}, 0);
        chk("idle_bus_req", BusReq, 0);
    endtask

    task automatic mem_set(input logic [1:0] we, input logic [31:0] a, input logic [31:0] w);
        MemReq = 1'b1; MemWe = we; MemAddr = a; MemWdata = w;
    endtask

    initial begin
        #12;
        chk("rst_bus_req", BusReq, 0);
        chk("rst_bus_we", BusWe, 0);
        chk("rst_bus_be", BusBe, 0);
        chk("rst_bus_addr", BusAddr, 0);
        chk("rst_bus_wdata", BusWdata, 0);
        chk("rst_if_rdata", IfRdata, 0);
        chk("rst_mem_rdata", MemRdata, 0);
        chk("rst_acks", {IfAck, MemAck}, 0);
        @(negedge Clk); Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Single IF read with two wait states
        @(negedge Clk); IfReq = 1'b1; IfAddr = 32'h0000_0040;
        serve(2, 1'b0, 32'h2402_0005);
        chk("if_read_data", IfRdata, 32'h2402_0005);

        // Byte, half, word stores on a zero-wait bus
        @(negedge Clk); mem_set(2'd1, 32'h1003, 32'h0000_00AB);
        serve(0, 1'b0, $urandom);
        @(negedge Clk); mem_set(2'd2, 32'h1002, 32'h0000_BEEF);
        serve(0, 1'b0, $urandom);
        @(negedge Clk); mem_set(2'd3, 32'h1001, 32'hCAFE_F00D);
        serve(0, 1'b0, $urandom);

        // Simultaneous requests: MEM first, IF three cycles later
        @(negedge Clk); IfReq = 1'b1; IfAddr = 32'h0000_0100; mem_set(2'd0, 32'h2000, '0);
        serve(0, 1'b0, $urandom);
        @(negedge Clk);
        serve(0, 1'b0, $urandom);

        // MEM hammering with IF waiting: starvation behaviour
        @(negedge Clk); IfReq = 1'b1; IfAddr = 32'h0000_0200;
        for (int r = 0; r < 6; r++) begin
            if (r > 0) @(negedge Clk);
            mem_set(2'($urandom_range(0, 3)), $urandom, $urandom);
            serve(0, 1'b0, $urandom);
        end
        @(negedge Clk); MemReq = 1'b0;
        if (IfReq) serve(0, 1'b0, $urandom);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            @(negedge Clk);
            if (!IfReq && $urandom_range(0, 1) == 1) begin
                IfReq = 1'b1; IfAddr = $urandom;
            end
            if (!MemReq && $urandom_range(0, 1) == 1)
                mem_set(2'($urandom_range(0, 3)), $urandom, $urandom);
            if (!IfReq && !MemReq) begin
                @(posedge Clk); #1;
                chk("idle_no_req", BusReq, 0);
                @(negedge Clk); IfReq = 1'b1; IfAddr = $urandom;
            end
            serve($urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom);
        end

        // Reset while BUSY abandons the transaction
        @(negedge Clk); IfReq = 1'b0; mem_set(2'd3, 32'h3000, 32'h1234_5678);
        @(posedge Clk); #1;
        chk("pre_rst_bus_req", BusReq, 1);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_rst_bus_req", BusReq, 0);
        chk("async_rst_acks", {IfAck, MemAck}, 0);
        chk("async_rst_mem_rdata", MemRdata, 0);
        MemReq = 1'b0; starve = 0; exp_if_rd = '0; exp_mem_rd = '0;
        @(negedge Clk); @(negedge Clk); Reset_n = 1'b1;
        @(posedge Clk); #1;
        chk("post_rst_idle", BusReq, 0);
        chk("post_rst_acks", {IfAck, MemAck}, 0);
        @(negedge Clk); IfReq = 1'b1; IfAddr = 32'h0000_0400;
        serve(1, 1'b0, 32'h0BAD_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
